// File: rtl/beep_pkg.sv
`default_nettype none
// +----------------------------------------------------------------+
// | beep_pkg: shared constants, FSM encoding and round-robin math  |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
package beep_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned DATA_W_DEF  = 8;

  typedef enum logic {
    ARB = 1'b0,
    WR  = 1'b1
  } arb_state_e;

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/beep_rr_picker.sv
`default_nettype none
// +----------------------------------------------------------------+
// | beep_rr_picker: first valid index at or after ptr, with wrap   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module beep_rr_picker #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     valid_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             found_o,
  output logic [IDX_W-1:0] idx_o
);

  logic [2*N-1:0] dbl_valid;
  logic [IDX_W:0] pos;

  // Doubling the vector turns the wrapped search into a straight scan from ptr.
  always_comb begin
    dbl_valid = {valid_i, valid_i};
    found_o   = 1'b0;
    idx_o     = '0;
    pos       = '0;
    for (int k = 0; k < int'(N); k++) begin
      pos = {1'b0, ptr_i} + (IDX_W+1)'(k);
      if (!found_o && dbl_valid[pos]) begin
        found_o = 1'b1;
        idx_o   = (pos >= (IDX_W+1)'(N)) ? IDX_W'(pos - (IDX_W+1)'(N)) : pos[IDX_W-1:0];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/beep_write_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------+
// | beep_write_arbiter: round-robin share of one FIFO write port   |
// | Rev 1.0                                                        |
// +----------------------------------------------------------------+
module beep_write_arbiter
  import beep_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         write_req,
  output logic [DATA_W-1:0]            fifo_write_data,
  input  logic                         full_sig,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         busy,
  output logic [CNT_W-1:0]             wr_count
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);

  arb_state_e          state_q, state_d;
  logic [NUM_REQ-1:0]  slot_valid_q, slot_valid_d;
  logic [DATA_W-1:0]   slot_data_q [NUM_REQ];
  logic [DATA_W-1:0]   slot_data_d [NUM_REQ];
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                write_req_q, write_req_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                pick_found;
  logic [IDX_W-1:0]    pick_idx;

  beep_rr_picker #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_picker (
    .valid_i (slot_valid_q),
    .ptr_i   (ptr_q),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d      = state_q;
    slot_valid_d = slot_valid_q;
    slot_data_d  = slot_data_q;
    ptr_d        = ptr_q;
    write_req_d  = 1'b0;
    wdata_d      = wdata_q;
    grant_d      = grant_q;
    cnt_d        = cnt_q;

    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (req_valid[i] && !slot_valid_q[i]) begin
        slot_valid_d[i] = 1'b1;
        slot_data_d[i]  = req_data[i*DATA_W +: DATA_W];
      end
    end

    // The mandatory WR cycle lets full_sig reflect the previous write before the next grant.
    case (state_q)
      ARB: begin
        if (!full_sig && pick_found) begin
          write_req_d            = 1'b1;
          wdata_d                = slot_data_q[pick_idx];
          grant_d                = pick_idx;
          slot_valid_d[pick_idx] = 1'b0;
          ptr_d                  = IDX_W'(rr_next(32'(pick_idx), NUM_REQ));
          cnt_d                  = cnt_q + CNT_W'(1);
          state_d                = WR;
        end
      end
      WR:      state_d = ARB;
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB;
      slot_valid_q <= '0;
      ptr_q        <= '0;
      write_req_q  <= 1'b0;
      wdata_q      <= '0;
      grant_q      <= '0;
      cnt_q        <= '0;
      for (int i = 0; i < int'(NUM_REQ); i++) slot_data_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      slot_valid_q <= slot_valid_d;
      ptr_q        <= ptr_d;
      write_req_q  <= write_req_d;
      wdata_q      <= wdata_d;
      grant_q      <= grant_d;
      cnt_q        <= cnt_d;
      slot_data_q  <= slot_data_d;
    end
  end

  assign req_ready       = ~slot_valid_q;
  assign write_req       = write_req_q;
  assign fifo_write_data = wdata_q;
  assign grant_id        = grant_q;
  assign wr_count        = cnt_q;
  assign busy            = (|slot_valid_q) | write_req_q;

endmodule
`default_nettype wire

// File: doc/beep_write_arbiter.md
Name: beep_write_arbiter

Overview:
Round-robin arbiter that shares the beep interface's single FIFO write port (write_req / fifo_write_data / full_sig) between NUM_REQ independent command sources, e.g. key scanner, UART decoder and alarm timer. Each source gets a one-entry holding slot with a valid/ready handshake. The arbiter drains the slots into the FIFO in round-robin order and never writes while the FIFO is full. It sits directly upstream of beep_interface_module.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, command byte width; must match the FIFO data width
CNT_W, 16, width of the accepted-write counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  requester i offers req_data slice i
req_data  in  NUM_REQ*DATA_W  requester i byte at bits [i*DATA_W +: DATA_W]
req_ready  out  NUM_REQ  slot i empty; capture occurs on valid&ready
write_req  out  1  FIFO write enable, registered
fifo_write_data  out  DATA_W  FIFO write data, registered
full_sig  in  1  FIFO full flag
grant_id  out  $clog2(NUM_REQ)  index of the requester whose byte is on fifo_write_data
busy  out  1  any slot valid or write_req high
wr_count  out  CNT_W  number of FIFO writes issued, wraps

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high, sampled on the rising edge of clk. All state updates on the rising edge of clk.
- Reset values:
  - slot_valid all 0, so req_ready all 1.
  - write_req 0, fifo_write_data 0, grant_id 0, wr_count 0, busy 0.
  - Round-robin pointer 0; FSM in ARB.
  - Reset asserted mid-operation discards all held bytes and any pending write.
- Capture: if req_valid[i] & req_ready[i] at an edge, slot i loads the byte and slot_valid[i] becomes 1. req_ready[i] = ~slot_valid[i], driven from a register.
- FSM has two states, ARB and WR.
  - ARB: if full_sig==0 and any slot is valid, pick the first valid slot searching from ptr upward with wrap. On the edge:
    - write_req<=1; fifo_write_data<=slot byte; grant_id<=index.
    - Clear that slot_valid; ptr<=index+1 (mod NUM_REQ).
    - wr_count<=wr_count+1; go to WR.
    - Otherwise write_req<=0 and stay in ARB.
  - WR: write_req<=0 and go to ARB, unconditionally.
- This gives at most one write every 2 cycles. full_sig is therefore always sampled after the previous write has updated it, so no overflow is possible.
- full_sig high in ARB: no grant, ptr unchanged, slots held. Requesters with full slots see req_ready=0 (backpressure).
- Latency: capture edge at t gives the earliest write_req high in cycle t+1 (registered), seen by the FIFO at the edge ending t+1.
- Grant and re-offer on the same slot: the slot cleared at edge t has req_ready=1 only from t+1. There is no same-cycle refill.
- Captures into other slots proceed in parallel with grants.
- Fairness: with all slots continuously refilled, the grant order is 0,1,2,3,0,...
  - Every requester is served within NUM_REQ writes, i.e. 2*NUM_REQ cycles when the FIFO is not full.
- wr_count wraps from 2^CNT_W-1 to 0 without saturation.
- grant_id and fifo_write_data hold their last values while write_req is 0.

Decomposition:
- Package beep_pkg holds:
  - NUM_REQ_DEF=4, DATA_W_DEF=8
  - FSM state enum (ARB=1'b0, WR=1'b1)
  - function rr_next(ptr) for wrap arithmetic
- One sub-module, beep_rr_picker: purely combinational.
  - Inputs: valid vector and ptr.
  - Outputs: found and index.
  - Implemented as a doubled-vector priority search.

Test Plan:
- Reset then a single request:
  - Stimulus: rst high 3 cycles then low; req_valid=4'b0100 with byte 0x5A for one cycle.
  - Response: req_ready[2] goes 0 next cycle; write_req pulses 1 cycle with fifo_write_data=0x5A, grant_id=2; wr_count=1.
- All four requesters valid simultaneously with bytes 0x10,0x11,0x12,0x13:
  - Writes in order 0x10,0x11,0x12,0x13.
  - Each write_req pulse is separated by exactly one low cycle; ptr ends at 0.
- Full backpressure:
  - Stimulus: hold full_sig=1 while slots 1 and 3 are loaded.
  - Response: no write_req and req_ready[1]=req_ready[3]=0.
  - Release full: writes of slot 1 then slot 3 begin within 1 cycle.
- Fairness under saturation:
  - Stimulus: requesters 0 and 3 refill on every ready for 20 writes.
  - Response: grants strictly alternate 0,3,0,3; no write occurs while full_sig=1.
- Reset mid-operation:
  - Stimulus: assert rst in the cycle write_req=1 with 3 slots valid.
  - Response: the next cycle shows write_req=0, all req_ready=1, wr_count=0; held bytes are never written.
- Counter wrap:
  - Stimulus: CNT_W=4, issue 17 writes.
  - Response: wr_count reads 15 after the 15th write, 0 after the 16th and 1 after the 17th.
